// File: rtl/experiment_emulator.sv
// Hardware-in-the-loop plant emulator driving the experiment-side inputs of fsm_experiment_phase.
// Optional macro EXPERIMENT_EMULATOR_PHASE_JITTER_EN adds 0..3 cycles of LFSR jitter per phase half-period.

module experiment_emulator #(
    parameter int PHASE_HALF       = 120,
    parameter int FG_PERIOD        = 2_000_000,
    parameter int FG_OPTO_LEN      = 200,
    parameter int FG_OPEN_DELAY    = 80_000,
    parameter int FG_OPEN_LEN      = 400_000,
    parameter int WIRE_DELAY       = 400,
    parameter int WIRE_LEN         = 200,
    parameter int DETECTOR_PROLONG = 1_280_000,
    parameter int CNT_W            = 32
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       enable,
    input  logic       detonator_triggered,
    input  logic       output_trigger,
    output logic       phase,
    output logic       fg_opto,
    output logic       fg_open,
    output logic       wire_sensor,
    output logic       detector_ready,
    output logic [2:0] emu_state,
    output logic       err_retrigger,
    output logic       err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_PULSE = 3'd2,
        S_DONE  = 3'd3
    } wire_state_t;

    localparam longint CNT_MAX      = (longint'(1) << CNT_W) - 1;
    localparam longint OPEN_END_RAW = longint'(FG_OPEN_DELAY) + longint'(FG_OPEN_LEN);
    // The open window never extends past the wrap, so its end is clamped to the period.
    localparam longint OPEN_END     = (OPEN_END_RAW > longint'(FG_PERIOD)) ? longint'(FG_PERIOD) : OPEN_END_RAW;

    localparam logic [CNT_W-1:0] ONE             = CNT_W'(1);
    localparam logic [CNT_W-1:0] PHASE_LAST      = CNT_W'(PHASE_HALF - 1);
    localparam logic [CNT_W-1:0] FG_LAST         = CNT_W'(FG_PERIOD - 1);
    localparam logic [CNT_W-1:0] OPTO_END        = CNT_W'(FG_OPTO_LEN);
    localparam logic [CNT_W-1:0] OPEN_START      = CNT_W'(FG_OPEN_DELAY);
    localparam logic [CNT_W-1:0] OPEN_STOP       = CNT_W'(OPEN_END);
    localparam logic [CNT_W-1:0] WIRE_WAIT_LAST  = CNT_W'(WIRE_DELAY - 1);
    localparam logic [CNT_W-1:0] WIRE_PULSE_LAST = CNT_W'(WIRE_LEN - 1);
    localparam logic [CNT_W-1:0] DET_LAST        = CNT_W'(DETECTOR_PROLONG - 1);

    generate
        if (CNT_W < 1 || CNT_W > 62) begin : g_bad_width
            $error("experiment_emulator: CNT_W must be in 1..62");
        end
        if (PHASE_HALF < 1 || FG_PERIOD < 1 || FG_OPTO_LEN < 0 || FG_OPEN_DELAY < 0 || FG_OPEN_LEN < 0 ||
            WIRE_DELAY < 1 || WIRE_LEN < 1 || DETECTOR_PROLONG < 1) begin : g_bad_range
            $error("experiment_emulator: timing parameter out of range");
        end
        if (longint'(PHASE_HALF) + 3 > CNT_MAX || longint'(FG_PERIOD) > CNT_MAX ||
            longint'(FG_OPTO_LEN) > CNT_MAX || longint'(FG_OPEN_DELAY) > CNT_MAX ||
            longint'(WIRE_DELAY) > CNT_MAX || longint'(WIRE_LEN) > CNT_MAX ||
            longint'(DETECTOR_PROLONG) > CNT_MAX) begin : g_bad_count
            $error("experiment_emulator: parameter exceeds 2^CNT_W-1");
        end
    endgenerate

    // enable=0 behaves like reset for every generator; only the sticky error flags survive it.
    logic hold;
    assign hold = reset_signal | ~enable;

    logic det_prev, trig_prev;
    logic det_edge, trig_edge;
    assign det_edge  = detonator_triggered & ~det_prev;
    assign trig_edge = output_trigger & ~trig_prev;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (hold) begin
            det_prev  <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            det_prev  <= detonator_triggered;
            trig_prev <= output_trigger;
        end
    end

    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_limit;

`ifdef EXPERIMENT_EMULATOR_PHASE_JITTER_EN
    logic [15:0] lfsr;
    assign phase_limit = PHASE_LAST + CNT_W'(lfsr[1:0]);

    always_ff @(posedge clock) begin
        if (hold) begin
            lfsr <= 16'hACE1;
        end else if (phase_cnt == phase_limit) begin
            // Galois form of taps 16,14,13,11.
            lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
        end
    end
`else
    assign phase_limit = PHASE_LAST;
`endif

    always_ff @(posedge clock) begin
        if (hold) begin
            phase_cnt <= '0;
            phase     <= 1'b0;
        end else if (phase_cnt == phase_limit) begin
            phase_cnt <= '0;
            phase     <= ~phase;
        end else begin
            phase_cnt <= phase_cnt + ONE;
        end
    end

    logic [CNT_W-1:0] fg_cnt;

    always_ff @(posedge clock) begin
        if (hold) begin
            fg_cnt  <= '0;
            fg_opto <= 1'b0;
            fg_open <= 1'b0;
        end else begin
            fg_opto <= (fg_cnt < OPTO_END);
            fg_open <= (fg_cnt >= OPEN_START) && (fg_cnt < OPEN_STOP);
            fg_cnt  <= (fg_cnt == FG_LAST) ? '0 : fg_cnt + ONE;
        end
    end

    wire_state_t      state, state_next;
    logic [CNT_W-1:0] wire_cnt, wire_cnt_next;
    logic             wire_next;

    always_ff @(posedge clock) begin
        if (hold) begin
            state       <= S_IDLE;
            wire_cnt    <= '0;
            wire_sensor <= 1'b0;
        end else begin
            state       <= state_next;
            wire_cnt    <= wire_cnt_next;
            wire_sensor <= wire_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next    = state;
        wire_cnt_next = wire_cnt + ONE;
        wire_next     = wire_sensor;
        case (state)
            S_IDLE: begin
                wire_cnt_next = '0;
                if (det_edge) begin
                    if (WIRE_DELAY == 1) begin
                        state_next = S_PULSE;
                        wire_next  = 1'b1;
                    end else begin
                        // Counter holds cycles elapsed since the edge cycle.
                        state_next    = S_WAIT;
                        wire_cnt_next = ONE;
                    end
                end
            end
            S_WAIT: begin
                if (wire_cnt == WIRE_WAIT_LAST) begin
                    state_next    = S_PULSE;
                    wire_next     = 1'b1;
                    wire_cnt_next = '0;
                end
            end
            S_PULSE: begin
                if (wire_cnt == WIRE_PULSE_LAST) begin
                    state_next    = S_DONE;
                    wire_next     = 1'b0;
                    wire_cnt_next = '0;
                end
            end
            S_DONE: begin
                state_next    = S_IDLE;
                wire_cnt_next = '0;
            end
            default: begin
                state_next    = S_IDLE;
                wire_next     = 1'b0;
                wire_cnt_next = '0;
            end
        endcase
    end

    assign emu_state = state;

    logic [CNT_W-1:0] det_cnt;

    always_ff @(posedge clock) begin
        if (hold) begin
            detector_ready <= 1'b1;
            det_cnt        <= '0;
        end else if (detector_ready) begin
            if (trig_edge) begin
                detector_ready <= 1'b0;
                det_cnt        <= '0;
            end
        end else if (det_cnt == DET_LAST) begin
            detector_ready <= 1'b1;
            det_cnt        <= '0;
        end else begin
            det_cnt <= det_cnt + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            err_retrigger <= 1'b0;
            err_overrun   <= 1'b0;
        end else if (enable) begin
            if (det_edge && state != S_IDLE) err_retrigger <= 1'b1;
            if (trig_edge && !detector_ready) err_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/experiment_emulator.md
Name: experiment_emulator

Overview:
- Synthesizable plant emulator for hardware-in-the-loop bring-up of fsm_experiment_phase on the 200 MHz (5 ns) clock.
- Drives the experiment-side inputs: phase, fg_opto, fg_open, wire_sensor and detector_ready.
- Reacts to the FSM's outputs, detonator_triggered and output_trigger, with programmable delays.
- Flags protocol violations, such as a re-trigger while the plant is busy. All timing parameters are in clock cycles.

Parameters:
- PHASE_HALF, 120, phase half-period (600 ns).
- FG_PERIOD, 2_000_000, fg_opto pulse period (10 ms).
- FG_OPTO_LEN, 200, fg_opto pulse width.
- FG_OPEN_DELAY, 80_000, cycles from fg_opto rise to fg_open rise (400 us).
- FG_OPEN_LEN, 400_000, fg_open high width.
- WIRE_DELAY, 400, cycles from detonator rising edge to wire_sensor rise (≥1).
- WIRE_LEN, 200, wire_sensor pulse width.
- DETECTOR_PROLONG, 1_280_000, detector_ready low time after output_trigger (6.4 ms).
- CNT_W, 32, width of every internal counter.

Ports:
- clock  in  1  system clock.
- reset_signal  in  1  synchronous, active-high reset.
- enable  in  1  run emulator; low holds all generators at their reset state.
- detonator_triggered  in  1  from FSM.
- output_trigger  in  1  from FSM.
- phase  out  1  phase square wave.
- fg_opto  out  1  frame-grabber opto pulse.
- fg_open  out  1  frame-grabber open window.
- wire_sensor  out  1  emulated wire-break pulse.
- detector_ready  out  1  detector ready level.
- emu_state  out  3  wire sequencer state encoding: IDLE=0, WAIT=1, PULSE=2, DONE=3.
- err_retrigger  out  1  sticky; detonator edge seen while wire sequencer not IDLE.
- err_overrun  out  1  sticky; output_trigger edge seen while detector_ready=0.

Behaviour:
- Reset values:
  - phase=0, fg_opto=0, fg_open=0, wire_sensor=0.
  - detector_ready=1, emu_state=IDLE, err_*=0.
  - All counters 0.
- All outputs are registered. Reset and enable=0 take effect on the next clock edge.
- Reset and enable=0 are equivalent, except that enable=0 does not clear err_* flags.
- Edge detect:
  - Input registered once (prev).
  - A rising edge is "edge cycle N" = first cycle the input is sampled 1 while prev=0.
  - A level held high is a single edge.
- Phase:
  - Counter counts 0..PHASE_HALF-1; phase toggles on wrap.
  - First toggle occurs PHASE_HALF cycles after enable rises.
- FG:
  - Period counter counts 0..FG_PERIOD-1 and wraps.
  - fg_opto=1 while count < FG_OPTO_LEN.
  - fg_open=1 while FG_OPEN_DELAY ≤ count < FG_OPEN_DELAY+FG_OPEN_LEN.
  - Both outputs are evaluated before the modulo wrap. A window exceeding FG_PERIOD is truncated at the wrap; no carry-over.
- Wire sequencer:
  - IDLE: on detonator edge cycle N, go to WAIT and load the counter.
  - WAIT: wire_sensor goes 1 at cycle N+WAIT_DELAY exactly, then state goes to PULSE.
  - PULSE: wire_sensor stays 1 for WIRE_LEN cycles, then 0 and state goes to DONE.
  - DONE: one cycle, then IDLE.
  - Detonator edge in WAIT, PULSE or DONE: ignored, err_retrigger=1 next cycle.
  - Edge in the same cycle DONE→IDLE: treated as retrigger, not accepted.
- Detector:
  - output_trigger edge at cycle N while detector_ready=1: detector_ready=0 at N+1.
  - detector_ready stays 0 for exactly DETECTOR_PROLONG cycles; back to 1 at N+1+DETECTOR_PROLONG.
  - Edge while 0: ignored, err_overrun=1 next cycle, low time not extended.
  - Edge on the cycle ready returns to 1: accepted.
- Detonator and output_trigger edges in the same cycle are handled independently.
- Counters saturate-free: each counter is only compared against its parameter and reloaded. No counter may exceed 2^CNT_W-1; this is an elaboration-time check on the parameters.

Optional Feature:
- Macro: EXPERIMENT_EMULATOR_PHASE_JITTER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) advances once per phase toggle.
  - Each half-period length becomes PHASE_HALF + lfsr[1:0], i.e. 0..3 extra cycles.
- Undefined:
  - No LFSR is present; half-period is exactly PHASE_HALF.

Test Plan:
- Reset then enable=1 with PHASE_HALF=120: phase rises at cycle 120, falls at 240, period 240 cycles stable over 50 periods; jitter macro off.
- FG_PERIOD=1000, FG_OPTO_LEN=20, FG_OPEN_DELAY=80, FG_OPEN_LEN=400:
  - fg_opto high on counts 0..19.
  - fg_open high on counts 80..479.
  - Repeats every 1000 cycles.
- Detonator edge at cycle 500 with WIRE_DELAY=400, WIRE_LEN=200:
  - wire_sensor high on cycles 900..1099.
  - emu_state sequence 0→1→2→3→0.
  - Second edge at 700 → err_retrigger=1 at 701, no second pulse.
- output_trigger edge at 1000 with DETECTOR_PROLONG=500:
  - detector_ready low on 1001..1500, high at 1501.
  - Edge at 1200 → err_overrun=1, ready still returns at 1501.
  - Edge at 1501 accepted → low again at 1502.
- Reset mid-WAIT and mid-detector-low: next cycle wire_sensor=0, emu_state=0, detector_ready=1, err flags 0; fresh edge then behaves as in the wire-sequencer and detector scenarios.
- Jitter macro on: each phase half-period measured in 120..123 cycles, sequence identical across two resets.
